display_controlador: RTL and testbench
======================================

# display_controlador

Scheduler for the shared 4-digit 7-segment display in the access-control system. It arbitrates between an always-present idle source, such as the free-slot count, and one-shot access messages, such as a plate or code. A message is held for a fixed time, with optional blinking, then followed by a blank gap. The block drives the display multiplexer's 16-bit digit word and enable, and generates that multiplexer's scan clock.

## Interface
Parameters:
- DIV_VARREDURA, 25000: clk cycles per half-period of clk_varredura.
- TEMPO_MSG, 100000000: clk cycles a message is displayed.
- TEMPO_GAP, 5000000: clk cycles the display is blanked after a message.
- DIV_PISCA, 25000000: clk cycles per blink phase (on or off).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- dados_ocioso  in  16  idle content, 4 BCD nibbles; [3:0] is the rightmost digit.
- msg_valid  in  1  message request.
- msg_dados  in  16  message content, 4 nibbles.
- msg_pisca  in  1  blink request; sampled with the message.
- msg_ready  out  1  message can be accepted.
- dados  out  16  digit word to the display multiplexer.
- on_off_DEMUX  out  1  display enable; 0 blanks all digits.
- clk_varredura  out  1  scan clock for the display multiplexer.
- ocupado  out  1  high while a message or gap is active.

## Operation
- Reset state and outputs (all outputs registered):
  - State OCIOSO, all counters 0.
  - dados=16'hAAAA; code 4'hA is the blank-digit code.
  - on_off_DEMUX=0, clk_varredura=0, msg_ready=0, ocupado=0.
- FSM states: OCIOSO, MENSAGEM, INTERVALO.
- OCIOSO:
  - dados <= dados_ocioso, after zero suppression if enabled.
  - on_off_DEMUX=1, msg_ready=1, ocupado=0.
  - Accept when msg_valid && msg_ready: latch msg_dados and msg_pisca, clear the hold and blink counters, go to MENSAGEM.
- MENSAGEM:
  - dados = latched message; msg_ready=0, ocupado=1.
  - msg_valid is ignored, so the requester must hold it until accepted.
  - Without blink: on_off_DEMUX=1.
  - With blink: on_off_DEMUX=1 for DIV_PISCA cycles, then 0 for DIV_PISCA cycles, repeating; always starts in the on phase.
  - After exactly TEMPO_MSG cycles, go to INTERVALO.
- INTERVALO:
  - on_off_DEMUX=0; dados holds the message; msg_ready=0, ocupado=1.
  - After TEMPO_GAP cycles, go to OCIOSO.
- Scan generator:
  - Free-running counter 0..DIV_VARREDURA-1, independent of the FSM.
  - clk_varredura toggles when the counter wraps.
- Counter widths: $clog2 of the respective parameter. A parameter value of 1 must work.
- Any 4-bit pattern passes through unchanged except where zero suppression applies.

## Timing
- Accept at edge t:
  - msg_ready falls at t+1.
  - dados equals the message and on_off_DEMUX=1 at t+1.
- Message visible on cycles t+1 .. t+TEMPO_MSG.
- INTERVALO covers cycles t+TEMPO_MSG+1 .. t+TEMPO_MSG+TEMPO_GAP.
- msg_ready=1 again at t+TEMPO_MSG+TEMPO_GAP+1.
- Idle-path latency: a dados_ocioso change appears on dados one cycle later.
- msg_valid in the same cycle that INTERVALO ends: not accepted; ready rises the next cycle.
- msg_valid asserted during reset: ignored. First acceptance is possible one cycle after rst falls.
- rst during MENSAGEM or INTERVALO: returns to reset values on the next edge; the pending message is discarded.
- clk_varredura period: 2*DIV_VARREDURA clk cycles. Unaffected by messages; reset only by rst.

## Configuration
- Macro SUPRIME_ZEROS_EN, defined:
  - In OCIOSO only, leading zero nibbles of dados_ocioso become 4'hA, scanning from nibble 3 down to the first nonzero nibble.
  - Nibble 0 is never blanked, so 16'h0000 displays as 16'hAAA0.
  - Messages are never modified.
- Macro not defined: dados_ocioso passes through unmodified.

## Structure
- Package display_pkg:
  - FSM state enum (OCIOSO, MENSAGEM, INTERVALO).
  - Constant DIGITO_APAGADO = 4'hA.
  - Constant DADOS_RESET = 16'hAAAA.
- Sub-module divisor_tick:
  - Parameterised modulus counter with a synchronous clear, emitting a one-cycle wrap pulse.
  - Instantiated twice: scan generator and blink phase.
- Hold and gap timing use a single shared down-counter, reloaded on each state entry.

## Test plan
Bench parameters: DIV_VARREDURA=2, TEMPO_MSG=10, TEMPO_GAP=3, DIV_PISCA=2.
- Reset, then dados_ocioso=16'h0042 -> dados=16'h0042 one cycle later (16'hAA42 with SUPRIME_ZEROS_EN); on_off_DEMUX=1, msg_ready=1.
- msg_valid with msg_dados=16'h1234, pisca=0, accepted at t -> dados=16'h1234 and on_off_DEMUX=1 for t+1..t+10; 0 for t+11..t+13; msg_ready=1 at t+14.
- Message with pisca=1 -> on_off_DEMUX pattern 1,1,0,0,1,1,0,0,1,1 over the 10 hold cycles.
- Second msg_valid held during MENSAGEM -> not accepted until t+14; accepted at t+14 and shown from t+15.
- rst pulsed mid-message -> next cycle dados=16'hAAAA, on_off_DEMUX=0, ocupado=0; idle content resumes after release.
- Free-running scan -> clk_varredura toggles every 2 cycles, period 4, with no change across message accept and gap transitions.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the 7-segment display scheduler.
// Zero suppression helper is used only when SUPRIME_ZEROS_EN is defined.
package display_pkg;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        MENSAGEM  = 2'd1,
        INTERVALO = 2'd2
    } estado_t;

    localparam logic [3:0]  DIGITO_APAGADO = 4'hA;
    localparam logic [15:0] DADOS_RESET    = 16'hAAAA;

    // Blank leading zero nibbles; the rightmost digit always stays visible.
    function automatic logic [15:0] suprime_zeros(input logic [15:0] d);
        logic [15:0] r;
        logic        lider;
        r     = d;
        lider = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            if (lider && d[i*4 +: 4] == 4'h0) begin
                r[i*4 +: 4] = DIGITO_APAGADO;
            end else begin
                lider = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/divisor_tick.sv
// Modulus counter with synchronous clear; o_tick is high on the
// last count, i.e. in the cycle before the counter wraps to zero.
module divisor_tick #(
    parameter int MODULO = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_limpa,
    output logic o_tick
);

    localparam int W = (MODULO > 1) ? $clog2(MODULO) : 1;
    localparam logic [W-1:0] ULTIMO = W'(MODULO - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_limpa) begin
            r_cnt <= '0;
        end else if (r_cnt == ULTIMO) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == ULTIMO);

endmodule

// File: rtl/display_controlador.sv
// Display scheduler: idle content vs. timed one-shot messages, plus scan clock.
// Define SUPRIME_ZEROS_EN to blank leading zeros of the idle content.
import display_pkg::*;

module display_controlador #(
    parameter int DIV_VARREDURA = 25000,
    parameter int TEMPO_MSG     = 100000000,
    parameter int TEMPO_GAP     = 5000000,
    parameter int DIV_PISCA     = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] dados_ocioso,
    input  logic        msg_valid,
    input  logic [15:0] msg_dados,
    input  logic        msg_pisca,
    output logic        msg_ready,
    output logic [15:0] dados,
    output logic        on_off_DEMUX,
    output logic        clk_varredura,
    output logic        ocupado
);

    localparam int MAX_T = (TEMPO_MSG > TEMPO_GAP) ? TEMPO_MSG : TEMPO_GAP;
    localparam int WT    = (MAX_T > 1) ? $clog2(MAX_T) : 1;
    localparam logic [WT-1:0] CARGA_MSG = WT'(TEMPO_MSG - 1);
    localparam logic [WT-1:0] CARGA_GAP = WT'(TEMPO_GAP - 1);

    estado_t     r_estado;
    logic [WT-1:0] r_cnt;
    logic [15:0] r_dados;
    logic        r_on;
    logic        r_ready;
    logic        r_ocup;
    logic        r_pisca;
    logic        r_fase;
    logic        r_varr;

    estado_t     w_prox_estado;
    logic [WT-1:0] w_prox_cnt;
    logic [15:0] w_prox_dados;
    logic        w_prox_on;
    logic        w_prox_ready;
    logic        w_prox_ocup;
    logic        w_prox_pisca;
    logic        w_prox_fase;

    logic [15:0] w_idle;
    logic        w_aceita;
    logic        w_tick_varr;
    logic        w_tick_pisca;

`ifdef SUPRIME_ZEROS_EN
    assign w_idle = suprime_zeros(dados_ocioso);
`else
    assign w_idle = dados_ocioso;
`endif

    assign w_aceita = msg_valid && r_ready;

    divisor_tick #(.MODULO(DIV_VARREDURA)) u_varredura (
        .clk     (clk),
        .rst     (rst),
        .i_limpa (1'b0),
        .o_tick  (w_tick_varr)
    );

    // Held in clear outside MENSAGEM so every message starts in the on phase.
    divisor_tick #(.MODULO(DIV_PISCA)) u_pisca (
        .clk     (clk),
        .rst     (rst),
        .i_limpa (r_estado != MENSAGEM),
        .o_tick  (w_tick_pisca)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_varr <= 1'b0;
        end else if (w_tick_varr) begin
            r_varr <= ~r_varr;
        end
    end

    always_comb begin
        w_prox_estado = r_estado;
        w_prox_cnt    = r_cnt;
        w_prox_dados  = r_dados;
        w_prox_on     = r_on;
        w_prox_ready  = r_ready;
        w_prox_ocup   = r_ocup;
        w_prox_pisca  = r_pisca;
        w_prox_fase   = r_fase;
        unique case (r_estado)
            OCIOSO: begin
                w_prox_dados = w_idle;
                w_prox_on    = 1'b1;
                w_prox_ready = 1'b1;
                w_prox_ocup  = 1'b0;
                if (w_aceita) begin
                    w_prox_estado = MENSAGEM;
                    w_prox_cnt    = CARGA_MSG;
                    w_prox_dados  = msg_dados;
                    w_prox_pisca  = msg_pisca;
                    w_prox_fase   = 1'b0;
                    w_prox_ready  = 1'b0;
                    w_prox_ocup   = 1'b1;
                end
            end
            MENSAGEM: begin
                w_prox_fase = r_fase ^ w_tick_pisca;
                w_prox_on   = !r_pisca || !(r_fase ^ w_tick_pisca);
                if (r_cnt == '0) begin
                    w_prox_estado = INTERVALO;
                    w_prox_cnt    = CARGA_GAP;
                    w_prox_on     = 1'b0;
                end else begin
                    w_prox_cnt = r_cnt - 1'b1;
                end
            end
            INTERVALO: begin
                w_prox_on = 1'b0;
                if (r_cnt == '0) begin
                    w_prox_estado = OCIOSO;
                    w_prox_dados  = w_idle;
                    w_prox_on     = 1'b1;
                    w_prox_ready  = 1'b1;
                    w_prox_ocup   = 1'b0;
                end else begin
                    w_prox_cnt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_prox_estado = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado <= OCIOSO;
            r_cnt    <= '0;
            r_dados  <= DADOS_RESET;
            r_on     <= 1'b0;
            r_ready  <= 1'b0;
            r_ocup   <= 1'b0;
            r_pisca  <= 1'b0;
            r_fase   <= 1'b0;
        end else begin
            r_estado <= w_prox_estado;
            r_cnt    <= w_prox_cnt;
            r_dados  <= w_prox_dados;
            r_on     <= w_prox_on;
            r_ready  <= w_prox_ready;
            r_ocup   <= w_prox_ocup;
            r_pisca  <= w_prox_pisca;
            r_fase   <= w_prox_fase;
        end
    end

    assign dados         = r_dados;
    assign on_off_DEMUX  = r_on;
    assign msg_ready     = r_ready;
    assign ocupado       = r_ocup;
    assign clk_varredura = r_varr;

endmodule

// File: tb/tb_display_controlador.sv
// Bench for display_controlador: directed scenarios plus random traffic
// checked every cycle against a timeline model of the display schedule.
module tb_display_controlador;

    localparam int DV = 2;
    localparam int TM = 10;
    localparam int TG = 3;
    localparam int DP = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] dados_ocioso;
    logic        msg_valid;
    logic [15:0] msg_dados;
    logic        msg_pisca;
    logic        msg_ready;
    logic [15:0] dados;
    logic        on_off_DEMUX;
    logic        clk_varredura;
    logic        ocupado;

    int total = 0;
    int bad   = 0;

    int          cyc    = 0;
    int          t_acc  = 0;
    int          n_scan = 0;
    bit          busy   = 1'b0;
    logic [15:0] m_msg  = 16'h0;
    bit          m_pisca = 1'b0;
    logic [15:0] e_dados = 16'hAAAA;
    bit          e_on    = 1'b0;
    bit          e_ready = 1'b0;
    bit          e_ocup  = 1'b0;

    always #5 clk = ~clk;

    display_controlador #(
        .DIV_VARREDURA (DV),
        .TEMPO_MSG     (TM),
        .TEMPO_GAP     (TG),
        .DIV_PISCA     (DP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .dados_ocioso  (dados_ocioso),
        .msg_valid     (msg_valid),
        .msg_dados     (msg_dados),
        .msg_pisca     (msg_pisca),
        .msg_ready     (msg_ready),
        .dados         (dados),
        .on_off_DEMUX  (on_off_DEMUX),
        .clk_varredura (clk_varredura),
        .ocupado       (ocupado)
    );

    function automatic logic [15:0] idle_ref(input logic [15:0] d);
        logic [15:0] r;
        int top;
        r   = d;
        top = 0;
`ifdef SUPRIME_ZEROS_EN
        for (int i = 0; i < 4; i++) begin
            if (d[i*4 +: 4] != 4'h0) top = i;
        end
        for (int i = top + 1; i < 4; i++) begin
            r[i*4 +: 4] = 4'hA;
        end
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h",
                   tag, cyc, obs, exp);
        end
    endtask

    // Advance one clock, update the schedule model, compare all outputs.
    task automatic step();
        bit pr;
        int k;
        @(posedge clk);
        cyc++;
        pr = e_ready;
        if (rst) begin
            n_scan  = 0;
            busy    = 1'b0;
            e_dados = 16'hAAAA;
            e_on    = 1'b0;
            e_ready = 1'b0;
            e_ocup  = 1'b0;
        end else begin
            n_scan++;
            k = cyc - t_acc;
            if (busy && k <= TM + TG) begin
                e_dados = m_msg;
                e_ready = 1'b0;
                e_ocup  = 1'b1;
                if (k <= TM)
                    e_on = m_pisca ? (((k - 1) / DP) % 2 == 0) : 1'b1;
                else
                    e_on = 1'b0;
            end else if (pr && msg_valid) begin
                busy    = 1'b1;
                t_acc   = cyc - 1;
                m_msg   = msg_dados;
                m_pisca = msg_pisca;
                e_dados = msg_dados;
                e_on    = 1'b1;
                e_ready = 1'b0;
                e_ocup  = 1'b1;
            end else begin
                busy    = 1'b0;
                e_dados = idle_ref(dados_ocioso);
                e_on    = 1'b1;
                e_ready = 1'b1;
                e_ocup  = 1'b0;
            end
        end
        #1;
        chk("dados", dados, e_dados);
        chk("on_off", 16'(on_off_DEMUX), 16'(e_on));
        chk("ready", 16'(msg_ready), 16'(e_ready));
        chk("ocupado", 16'(ocupado), 16'(e_ocup));
        chk("varredura", 16'(clk_varredura), 16'((n_scan / DV) % 2));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        bit pat [10];
        logic [15:0] msg_b;
        pat = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1};

        // Reset with a request pending: must be ignored.
        rst          = 1'b1;
        msg_valid    = 1'b1;
        msg_dados    = 16'h9999;
        msg_pisca    = 1'b0;
        dados_ocioso = 16'h0000;
        steps(3);
        chk("rst_dados", dados, 16'hAAAA);
        chk("rst_ready", 16'(msg_ready), 16'h0);

        // Idle path.
        rst          = 1'b0;
        msg_valid    = 1'b0;
        dados_ocioso = 16'h0042;
        step();
`ifdef SUPRIME_ZEROS_EN
        chk("idle_0042", dados, 16'hAA42);
`else
        chk("idle_0042", dados, 16'h0042);
`endif
        chk("idle_on", 16'(on_off_DEMUX), 16'h1);
        dados_ocioso = 16'h0000;
        steps(2);

        // Plain message.
        msg_valid = 1'b1;
        msg_dados = 16'h1234;
        msg_pisca = 1'b0;
        step();
        chk("msg_first", dados, 16'h1234);
        msg_valid    = 1'b0;
        dados_ocioso = 16'h0705;
        steps(9);
        chk("msg_last_on", 16'(on_off_DEMUX), 16'h1);
        step();
        chk("gap_off", 16'(on_off_DEMUX), 16'h0);
        steps(2);
        chk("gap_hold", dados, 16'h1234);
        step();
        chk("ready_back", 16'(msg_ready), 16'h1);

        // Blinking message.
        msg_valid = 1'b1;
        msg_dados = 16'h8A0F;
        msg_pisca = 1'b1;
        step();
        msg_valid = 1'b0;
        chk("blink_k1", 16'(on_off_DEMUX), 16'(pat[0]));
        for (int k = 1; k < 10; k++) begin
            step();
            chk("blink_pat", 16'(on_off_DEMUX), 16'(pat[k]));
        end
        steps(5);

        // Held request while busy: second message waits for ready.
        msg_b     = 16'($urandom);
        msg_valid = 1'b1;
        msg_dados = 16'h5678;
        msg_pisca = 1'b0;
        step();
        msg_dados = msg_b;
        steps(13);
        chk("held_wait", 16'(msg_ready), 16'h1);
        step();
        chk("held_accept", dados, msg_b);
        msg_valid = 1'b0;
        steps(14);

        // Reset mid-message.
        msg_valid = 1'b1;
        msg_dados = 16'h4321;
        step();
        msg_valid = 1'b0;
        steps(4);
        rst = 1'b1;
        step();
        chk("midrst_dados", dados, 16'hAAAA);
        chk("midrst_ocup", 16'(ocupado), 16'h0);
        rst          = 1'b0;
        dados_ocioso = 16'h0300;
        steps(2);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 79) == 0);
            msg_valid = ($urandom_range(0, 5) == 0);
            msg_dados = 16'($urandom);
            msg_pisca = 1'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: dados_ocioso = 16'h0000;
                    1: dados_ocioso = {8'h00, 8'($urandom)};
                    2: dados_ocioso = {12'h000, 4'($urandom)};
                    default: dados_ocioso = 16'($urandom);
                endcase
            end
            step();
        end
        rst       = 1'b0;
        msg_valid = 1'b0;
        steps(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
